// File: rtl/nzcv_flag_unit_if.sv
// Execute-side bundle between the issuing pipeline and the NZCV flag unit.
// No latency of its own; pure wiring with direction-specific modports.
// Backpressure is carried as stall/flush from the hazard unit, not as valid/ready.
interface nzcv_flag_unit_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_s;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_shift_c;
  logic         msr_we;
  logic [3:0]   msr_nzcv;
  logic         stall;
  logic         flush;
  logic [3:0]   nzcv_out;
  logic [3:0]   nzcv_fwd;
  logic         pend_valid;

  // Pipeline / hazard-unit side: drives the instruction and control, observes flags.
  modport master (
    output in_valid, in_s, in_op, in_a, in_b, in_shift_c,
    output msr_we, msr_nzcv, stall, flush,
    input  nzcv_out, nzcv_fwd, pend_valid
  );

  // Flag unit side.
  modport slave (
    input  in_valid, in_s, in_op, in_a, in_b, in_shift_c,
    input  msr_we, msr_nzcv, stall, flush,
    output nzcv_out, nzcv_fwd, pend_valid
  );
endinterface

// File: rtl/nzcv_flag_unit.sv
// NZCV producer: computes flags for flag-setting ops, holds them pending, then commits.
// Latency: capture at edge t -> nzcv_fwd after t, nzcv_out after t+1.
// stall freezes all state; flush drops the pending and the incoming update.
module nzcv_flag_unit #(
  parameter int W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  nzcv_flag_unit_if.slave     bus
);

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_MVN = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_ADC = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SBC = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_ORR = 4'd7;
  localparam logic [3:0] OP_EOR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;
  localparam logic [3:0] OP_TST = 4'd10;
  localparam logic [3:0] OP_RSB = 4'd11;

  // Architectural and pending state
  logic [3:0]   r_nzcv_out;
  logic [3:0]   r_pend_nzcv;
  logic         r_pend_valid;

  // Forwarded view and the carry/overflow an arithmetic op consumes
  logic [3:0]   w_fwd;
  logic         w_c_eff;
  logic         w_v_eff;

  // Adder operands and result
  logic [W-1:0] w_add_x;
  logic [W-1:0] w_add_y;
  logic         w_add_cin;
  logic [W:0]   w_sum;
  logic         w_is_arith;

  // Flag computation
  logic [W-1:0] w_res;
  logic         w_n;
  logic         w_z;
  logic         w_c;
  logic         w_v;
  logic         w_cap;
  logic [3:0]   w_cap_val;

  // Newest flags win: a pending update shadows the committed register.
  assign w_fwd   = r_pend_valid ? r_pend_nzcv : r_nzcv_out;
  assign w_c_eff = w_fwd[1];
  assign w_v_eff = w_fwd[0];

  // Select adder inputs; subtraction is done as x + ~y + carry-in.
  always_comb begin
    w_add_x    = bus.in_a;
    w_add_y    = bus.in_b;
    w_add_cin  = 1'b0;
    w_is_arith = 1'b0;
    unique case (bus.in_op)
      OP_ADD: begin
        w_is_arith = 1'b1;
      end
      OP_ADC: begin
        w_add_cin  = w_c_eff;
        w_is_arith = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        w_add_y    = ~bus.in_b;
        w_add_cin  = 1'b1;
        w_is_arith = 1'b1;
      end
      OP_SBC: begin
        w_add_y    = ~bus.in_b;
        w_add_cin  = w_c_eff;
        w_is_arith = 1'b1;
      end
      OP_RSB: begin
        w_add_x    = bus.in_b;
        w_add_y    = ~bus.in_a;
        w_add_cin  = 1'b1;
        w_is_arith = 1'b1;
      end
      default: begin
        w_is_arith = 1'b0;
      end
    endcase
  end

  // W+1-bit sum so the top bit is the architectural carry-out.
  assign w_sum = {1'b0, w_add_x} + {1'b0, w_add_y} + {{W{1'b0}}, w_add_cin};

  // Result mux and N/Z/C/V; logical ops take C from the shifter and keep V.
  always_comb begin
    w_res = '0;
    unique case (bus.in_op)
      OP_MOV:         w_res = bus.in_b;
      OP_MVN:         w_res = ~bus.in_b;
      OP_AND, OP_TST: w_res = bus.in_a & bus.in_b;
      OP_ORR:         w_res = bus.in_a | bus.in_b;
      OP_EOR:         w_res = bus.in_a ^ bus.in_b;
      default:        w_res = w_is_arith ? w_sum[W-1:0] : '0;
    endcase

    w_n = w_res[W-1];
    w_z = (w_res == '0);
    if (w_is_arith) begin
      w_c = w_sum[W];
      w_v = (w_add_x[W-1] == w_add_y[W-1]) && (w_res[W-1] != w_add_x[W-1]);
    end else begin
      w_c = bus.in_shift_c;
      w_v = w_v_eff;
    end
  end

  // A direct flag write beats a concurrent flag-setting instruction.
  assign w_cap     = bus.msr_we | (bus.in_valid & bus.in_s & (bus.in_op <= OP_RSB));
  assign w_cap_val = bus.msr_we ? bus.msr_nzcv : {w_n, w_z, w_c, w_v};

  // Two-stage flag pipeline: reset > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_nzcv_out   <= 4'b0000;
      r_pend_nzcv  <= 4'b0000;
      r_pend_valid <= 1'b0;
    end else if (bus.flush) begin
      r_pend_valid <= 1'b0;
    end else if (!bus.stall) begin
      if (r_pend_valid) begin
        r_nzcv_out <= r_pend_nzcv;
      end
      r_pend_valid <= w_cap;
      if (w_cap) begin
        r_pend_nzcv <= w_cap_val;
      end
    end
  end

  assign bus.nzcv_out   = r_nzcv_out;
  assign bus.nzcv_fwd   = w_fwd;
  assign bus.pend_valid = r_pend_valid;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed bench for nzcv_flag_unit with hand-computed flag vectors.
// Drives inputs 1 time unit after each rising edge and samples there too.
// Stall/flush sequences exercise hold and discard of the pending stage.
module tb_nzcv_flag_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  nzcv_flag_unit_if #(.W(32)) bus ();

  nzcv_flag_unit #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs[3:0], exp[3:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid   = 1'b0;
    bus.in_s       = 1'b0;
    bus.in_op      = 4'd0;
    bus.in_a       = 32'd0;
    bus.in_b       = 32'd0;
    bus.in_shift_c = 1'b0;
    bus.msr_we     = 1'b0;
    bus.msr_nzcv   = 4'd0;
    bus.stall      = 1'b0;
    bus.flush      = 1'b0;
  endtask

  task automatic op_s(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic sc);
    bus.in_valid   = 1'b1;
    bus.in_s       = 1'b1;
    bus.in_op      = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_shift_c = sc;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] fwd, input logic [3:0] out,
                           input logic pv);
    check({tag, ".fwd"}, {28'd0, bus.nzcv_fwd}, {28'd0, fwd});
    check({tag, ".out"}, {28'd0, bus.nzcv_out}, {28'd0, out});
    check({tag, ".pv"},  {31'd0, bus.pend_valid}, {31'd0, pv});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle();

    // Reset overrides stall, flush and a concurrent direct write.
    rst_n        = 1'b0;
    bus.stall    = 1'b1;
    bus.flush    = 1'b1;
    bus.msr_we   = 1'b1;
    bus.msr_nzcv = 4'b1111;
    step();
    step();
    chk_state("reset", 4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    idle();
    step();
    chk_state("post_reset", 4'b0000, 4'b0000, 1'b0);

    // ADD overflow: 7FFFFFFF + 1 -> N=1, V=1.
    op_s(4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    chk_state("add_ovf", 4'b1001, 4'b0000, 1'b1);
    idle();
    step();
    chk_state("add_commit", 4'b1001, 4'b1001, 1'b0);

    // SUB 5-5 then SBC 0-0 using forwarded C=1.
    op_s(4'd4, 32'd5, 32'd5, 1'b0);
    step();
    chk_state("sub_eq", 4'b0110, 4'b1001, 1'b1);
    op_s(4'd5, 32'd0, 32'd0, 1'b0);
    step();
    chk_state("sbc_fwd", 4'b0110, 4'b0110, 1'b1);
    // ADC FFFFFFFF + 0 + Ceff(1) wraps to zero; without the forwarded carry it would be 1000.
    op_s(4'd3, 32'hFFFF_FFFF, 32'd0, 1'b0);
    step();
    chk_state("adc_fwd", 4'b0110, 4'b0110, 1'b1);
    idle();
    step();
    chk_state("adc_commit", 4'b0110, 4'b0110, 1'b0);

    // Direct write, then AND keeps V from the forwarded flags and takes C from shifter.
    bus.msr_we   = 1'b1;
    bus.msr_nzcv = 4'b0011;
    step();
    chk_state("msr", 4'b0011, 4'b0110, 1'b1);
    idle();
    op_s(4'd6, 32'hF000_0000, 32'hF000_0000, 1'b0);
    step();
    chk_state("and_keep_v", 4'b1001, 4'b0011, 1'b1);
    // Same op alongside a direct write: the write wins.
    bus.msr_we   = 1'b1;
    bus.msr_nzcv = 4'b0101;
    step();
    chk_state("msr_wins", 4'b0101, 4'b1001, 1'b1);
    idle();
    step();
    chk_state("msr_commit", 4'b0101, 4'b0101, 1'b0);

    // CMP 0-1 then flush together with an incoming flag op: nothing commits.
    op_s(4'd9, 32'd0, 32'd1, 1'b0);
    step();
    chk_state("cmp", 4'b1000, 4'b0101, 1'b1);
    op_s(4'd2, 32'd0, 32'd0, 1'b0);
    bus.flush = 1'b1;
    step();
    chk_state("flush", 4'b0101, 4'b0101, 1'b0);
    idle();
    step();
    chk_state("after_flush", 4'b0101, 4'b0101, 1'b0);

    // ADD FFFFFFFF+1 then three stalled edges, with a would-be capture presented meanwhile.
    op_s(4'd2, 32'hFFFF_FFFF, 32'd1, 1'b0);
    step();
    chk_state("add_wrap", 4'b0110, 4'b0101, 1'b1);
    op_s(4'd0, 32'd0, 32'd0, 1'b0);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_state($sformatf("stall%0d", i), 4'b0110, 4'b0101, 1'b1);
    end
    idle();
    step();
    chk_state("stall_release", 4'b0110, 4'b0110, 1'b0);

    // MVN with shifter carry, then a non-S op: pending commits, nothing captured.
    op_s(4'd1, 32'd0, 32'd0, 1'b1);
    step();
    chk_state("mvn", 4'b1010, 4'b0110, 1'b1);
    op_s(4'd2, 32'd0, 32'd0, 1'b0);
    bus.in_s = 1'b0;
    step();
    chk_state("no_s", 4'b1010, 4'b1010, 1'b0);

    // EOR to zero, then an undefined op code with S set.
    op_s(4'd8, 32'd5, 32'd5, 1'b0);
    step();
    chk_state("eor", 4'b0100, 4'b1010, 1'b1);
    op_s(4'd13, 32'd0, 32'd0, 1'b1);
    step();
    chk_state("op13", 4'b0100, 4'b0100, 1'b0);

    // RSB 0-1 -> FFFFFFFF, borrow so C=0.
    op_s(4'd11, 32'd1, 32'd0, 1'b0);
    step();
    chk_state("rsb", 4'b1000, 4'b0100, 1'b1);
    // ORR with shifter carry keeps V (0).
    op_s(4'd7, 32'h0000_0F00, 32'h0000_00F0, 1'b1);
    step();
    chk_state("orr", 4'b0010, 4'b1000, 1'b1);
    idle();
    step();
    chk_state("orr_commit", 4'b0010, 4'b0010, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/nzcv_flag_unit.md
Name: nzcv_flag_unit

Overview:
- Producer end of the condition-code path. Computes the N, Z, C and V flags for flag-setting data-processing ops.
- Holds the flags in a two-stage pipeline: a pending stage, then the architectural status register.
- Drives the forwarded 4-bit NZCV vector that the condition checker consumes, with bit 3=N, 2=Z, 1=C, 0=V.
- Sits beside the execute-stage ALU. Pipeline control comes from the hazard unit through stall and flush.

Parameters:
- W, 32, operand/result width in bits; W >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  an instruction is present in execute this cycle.
- in_s  in  1  the instruction's S bit (set flags).
- in_op  in  4  op code: 0 MOV, 1 MVN, 2 ADD, 3 ADC, 4 SUB, 5 SBC, 6 AND, 7 ORR, 8 EOR, 9 CMP, 10 TST, 11 RSB. Codes 12-15 never update flags.
- in_a  in  W  first operand (Rn).
- in_b  in  W  second operand (shifter output).
- in_shift_c  in  1  shifter carry-out, used as C for logical ops.
- msr_we  in  1  direct flag write.
- msr_nzcv  in  4  value for a direct flag write.
- stall  in  1  freeze the unit.
- flush  in  1  kill pending and incoming updates.
- nzcv_out  out  4  committed status register.
- nzcv_fwd  out  4  newest flags; feeds the condition checker.
- pend_valid  out  1  a pending flag update is in flight.

Behaviour:
- Reset (rst_n=0 at an edge): nzcv_out=0000, pend_valid=0, pending value=0000, so nzcv_fwd=0000. Reset overrides stall, flush and all inputs.
- Forwarding is combinational: nzcv_fwd = pend_valid ? pend_nzcv : nzcv_out. Ceff and Veff below are bits 1 and 0 of nzcv_fwd.
- Result R (internal, W bits):
  - MOV: b. MVN: ~b.
  - ADD: a+b. ADC: a+b+Ceff.
  - SUB/CMP: a+~b+1. SBC: a+~b+Ceff. RSB: b+~a+1.
  - AND/TST: a&b. ORR: a|b. EOR: a^b.
- N = R[W-1]. Z = (R==0).
- C for arithmetic ops: the carry-out of the (W+1)-bit sum above. For SUB this means C=1 exactly when a>=b unsigned.
- V for arithmetic ops: the two adder inputs (after inversion) have equal MSBs and R[W-1] differs from them.
- Logical ops and MOV/MVN: C = in_shift_c, V = Veff (unchanged).
- Capture condition: cap = msr_we | (in_valid & in_s & in_op<=11).
- Capture value: msr_nzcv when msr_we=1 (msr_we wins if both are asserted), otherwise the computed {N,Z,C,V}.
- Per-edge priority when rst_n=1:
  1. flush: pend_valid<=0, no capture, nzcv_out unchanged.
  2. stall: all state holds.
  3. Otherwise:
     - If pend_valid, then nzcv_out<=pend_nzcv.
     - pend_valid<=cap.
     - If cap, then pend_nzcv<=capture value.
- Latency: a capture at edge t makes the value visible on nzcv_fwd after t and on nzcv_out after t+1.
- Back-to-back flag ops: the second op sees the first op's flags via Ceff/Veff. Both commit in order, and the later op's flags end up in nzcv_out.
- Non-flag cycles (cap=0): the pending value still commits, and pend_valid drops to 0, so nzcv_fwd = nzcv_out afterwards.
- Flush with pend_valid=1: the pending update is discarded and never reaches nzcv_out.
- A stall asserted mid-sequence delays the commit by exactly the number of stalled cycles. nzcv_fwd stays stable throughout.

Test Plan:
- Reset, then W=32, ADD S: a=7FFFFFFF, b=1. Required: nzcv_fwd=1001 after the edge, nzcv_out=1001 one edge later, pend_valid 1 then 0.
- SUB S a=5, b=5 (expect 0110), followed next cycle by SBC S a=0, b=0. SBC uses forwarded C=1, so R=0. Required: nzcv_fwd=0110, then nzcv_out ends at 0110.
- Set flags to 0011 via msr_we, then AND S with a=F0000000, b=F0000000, in_shift_c=0. Required: nzcv=1001 (V kept from 1, C=0). The same cycle with msr_we=1 must take msr_nzcv instead.
- CMP S a=0, b=1, then flush on the next edge. Required: pend_valid=0, nzcv_out keeps its prior value, the 1000 flags are never committed.
- ADD S a=FFFFFFFF, b=1 with stall=1 for 3 cycles before the commit edge. Required: nzcv_fwd=0110 held, nzcv_out unchanged until the first unstalled edge.
- in_valid=1, in_s=0, or in_op=13, with a pending flag op. Required: the pending value commits, pend_valid=0, no new capture.
